aes_kat_monitor: RTL and testbench

Sequential known-answer-test (KAT) controller for the AES datapath, sitting between the AES cipher/decipher engine and the board I/O. On a `run` request it sweeps a masked set of FIPS-197 test vectors through the engine using a start/done handshake. For each vector it compares the result against the expected block, with a per-vector timeout, and latches per-vector pass/fail. It drives a parametrised bank of active-low 7-segment digits showing a selectable window of the last captured result in hex.

---
 rtl/aes_kat_pkg.sv | 50 +++++
 rtl/hex_digit_7seg.sv | 30 +++
 rtl/aes_kat_monitor.sv | 137 +++++++++++++
 tb/tb_aes_kat_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_kat_pkg.sv
// Shared definitions for the AES known-answer-test monitor: FSM states,
// key-size encodings and the FIPS-197 vector table.
package aes_kat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_ADVANCE,
        ST_FINISH
    } kat_state_t;

    localparam logic [1:0] KEY_128 = 2'b00;
    localparam logic [1:0] KEY_192 = 2'b01;
    localparam logic [1:0] KEY_256 = 2'b10;

    localparam logic [127:0] KAT_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] KAT_CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    // Even indices encrypt the common plaintext, odd indices decrypt it back.
    function automatic logic [127:0] kat_input(input logic [2:0] idx);
        case (idx)
            3'd1:    return KAT_CT_128;
            3'd3:    return KAT_CT_192;
            3'd5:    return KAT_CT_256;
            default: return KAT_PT;
        endcase
    endfunction

    function automatic logic [127:0] kat_expected(input logic [2:0] idx);
        case (idx)
            3'd0:    return KAT_CT_128;
            3'd2:    return KAT_CT_192;
            3'd4:    return KAT_CT_256;
            default: return KAT_PT;
        endcase
    endfunction

    function automatic logic [1:0] kat_keysize(input logic [2:0] idx);
        case (idx[2:1])
            2'd0:    return KEY_128;
            2'd1:    return KEY_192;
            default: return KEY_256;
        endcase
    endfunction

endpackage

// File: rtl/hex_digit_7seg.sv
// Nibble to active-low 7-segment pattern, segment g in bit 6.
module hex_digit_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b0000011;
            4'hc: seg = 7'b1000110;
            4'hd: seg = 7'b0100001;
            4'he: seg = 7'b0000110;
            4'hf: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/aes_kat_monitor.sv
// Sweeps the masked FIPS-197 vectors through the AES engine, records
// per-vector pass/fail/timeout and shows the last result on 7-seg digits.
module aes_kat_monitor
    import aes_kat_pkg::*;
#(
    parameter int NUM_VECTORS    = 6,
    parameter int NUM_DIGITS     = 6,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [NUM_VECTORS-1:0]  vec_mask,
    input  logic [3:0]              disp_byte,
    output logic                    eng_start,
    output logic [1:0]              eng_keysize,
    output logic                    eng_decrypt,
    output logic [127:0]            eng_block_in,
    input  logic                    eng_done,
    input  logic [127:0]            eng_result,
    output logic                    busy,
    output logic                    done,
    output logic                    pass_all,
    output logic [NUM_VECTORS-1:0]  fail_vec,
    output logic [NUM_VECTORS-1:0]  timeout_vec,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    kat_state_t             state, state_nxt;
    logic [2:0]             idx;
    logic [2:0]             idx_inc;
    logic [NUM_VECTORS-1:0] mask;
    logic [CW-1:0]          cnt;
    logic [127:0]           disp_reg;
    logic                   last_idx;
    logic                   expired;

    assign idx_inc  = idx + 3'd1;
    assign last_idx = (idx == 3'(NUM_VECTORS - 1));
    assign expired  = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (run) state_nxt = vec_mask[0] ? ST_LAUNCH : ST_ADVANCE;
            ST_LAUNCH:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (eng_done)     state_nxt = ST_CHECK;
                else if (expired) state_nxt = ST_ADVANCE;
            end
            ST_CHECK:   state_nxt = ST_ADVANCE;
            ST_ADVANCE: begin
                if (last_idx)           state_nxt = ST_FINISH;
                else if (mask[idx_inc]) state_nxt = ST_LAUNCH;
            end
            ST_FINISH:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Engine request stays tied to the held index from LAUNCH through CHECK.
    always_comb begin
        logic active;
        active       = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_CHECK);
        eng_start    = (state == ST_LAUNCH);
        eng_keysize  = active ? kat_keysize(idx) : 2'b00;
        eng_decrypt  = active ? idx[0] : 1'b0;
        eng_block_in = active ? kat_input(idx) : '0;
        busy         = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            mask        <= '0;
            cnt         <= '0;
            disp_reg    <= '0;
            done        <= 1'b0;
            pass_all    <= 1'b0;
            fail_vec    <= '0;
            timeout_vec <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        mask        <= vec_mask;
                        idx         <= '0;
                        done        <= 1'b0;
                        pass_all    <= 1'b0;
                        fail_vec    <= '0;
                        timeout_vec <= '0;
                    end
                end
                ST_LAUNCH: cnt <= '0;
                ST_WAIT: begin
                    if (eng_done) begin
                        disp_reg <= eng_result;
                    end else if (expired) begin
                        fail_vec[idx]    <= 1'b1;
                        timeout_vec[idx] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (disp_reg != kat_expected(idx)) fail_vec[idx] <= 1'b1;
                end
                ST_ADVANCE: begin
                    if (!last_idx) idx <= idx_inc;
                end
                ST_FINISH: begin
                    done     <= 1'b1;
                    pass_all <= (mask != '0) && (fail_vec == '0);
                end
                default: ;
            endcase
        end
    end

    // Byte window wraps modulo 16; low nibble on the even digit of each pair.
    for (genvar k = 0; k < NUM_DIGITS / 2; k++) begin : g_pair
        logic [3:0] sel;
        logic [7:0] byte_val;
        assign sel      = disp_byte + 4'(k);
        assign byte_val = disp_reg[{sel, 3'b000} +: 8];
        hex_digit_7seg u_lo (.nibble(byte_val[3:0]), .seg(hex[14*k +: 7]));
        hex_digit_7seg u_hi (.nibble(byte_val[7:4]), .seg(hex[14*k+7 +: 7]));
    end

endmodule

// File: tb/tb_aes_kat_monitor.sv
// Scoreboard bench for aes_kat_monitor with a behavioural AES engine model.
module tb_aes_kat_monitor;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         run = 1'b0;
    logic [5:0]   vec_mask = '0;
    logic [3:0]   disp_byte = '0;
    logic         eng_start;
    logic [1:0]   eng_keysize;
    logic         eng_decrypt;
    logic [127:0] eng_block_in;
    logic         eng_done = 1'b0;
    logic [127:0] eng_result = '0;
    logic         busy, done, pass_all;
    logic [5:0]   fail_vec, timeout_vec;
    logic [41:0]  hex;

    int total = 0;
    int bad = 0;

    int eng_lat = 3;
    int eng_bad = -1;
    int eng_silent = -1;
    int eng_cnt = 0;
    int eng_idx = 0;

    logic [2:0]  start_q[$];
    logic [19:0] result_q[$];

    aes_kat_monitor dut (
        .clk(clk), .reset(reset), .run(run), .vec_mask(vec_mask), .disp_byte(disp_byte),
        .eng_start(eng_start), .eng_keysize(eng_keysize), .eng_decrypt(eng_decrypt),
        .eng_block_in(eng_block_in), .eng_done(eng_done), .eng_result(eng_result),
        .busy(busy), .done(done), .pass_all(pass_all), .fail_vec(fail_vec),
        .timeout_vec(timeout_vec), .hex(hex)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] tb_input(input int i);
        case (i)
            1:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            3:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            5:       return 128'h8ea2b7ca516745bfeafc49904b496089;
            default: return 128'h00112233445566778899aabbccddeeff;
        endcase
    endfunction

    function automatic logic [127:0] tb_expected(input int i);
        case (i)
            0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            2:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            4:       return 128'h8ea2b7ca516745bfeafc49904b496089;
            default: return 128'h00112233445566778899aabbccddeeff;
        endcase
    endfunction

    function automatic logic [6:0] tb_seg(input logic [3:0] n);
        logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    function automatic logic [41:0] tb_hex(input logic [127:0] blk, input logic [3:0] db);
        logic [41:0] h;
        logic [3:0]  b;
        logic [7:0]  v;
        h = '0;
        for (int k = 0; k < 3; k++) begin
            b = db + 4'(k);
            v = 8'(blk >> (int'(b) * 8));
            h[14*k +: 7]   = tb_seg(v[3:0]);
            h[14*k+7 +: 7] = tb_seg(v[7:4]);
        end
        return h;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: answers L cycles after the start pulse, unless told to stay silent.
    always @(negedge clk) begin
        if (!reset) begin
            eng_cnt  = 0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (eng_start) begin
                eng_idx = int'(eng_keysize) * 2 + int'(eng_decrypt);
                eng_cnt = (eng_idx == eng_silent) ? 0 : eng_lat;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done   = 1'b1;
                    eng_result = tb_expected(eng_idx) ^ ((eng_idx == eng_bad) ? 128'd1 : 128'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (eng_start) begin
            if (start_q.size() == 0) begin
                checkOutput("unexpected_start", 1, 0);
            end else begin
                logic [2:0] e;
                e = start_q.pop_front();
                checkOutput("start_cfg", {eng_keysize, eng_decrypt}, {1'b0, e[2:1], e[0]});
                checkOutput("block_in", eng_block_in, tb_input(int'(e)));
            end
        end
    end

    task automatic pulseRun(input logic [5:0] m);
        @(negedge clk);
        vec_mask = m;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic applyStimulus(input logic [5:0] m, input int lat, input int bv, input int sv);
        logic [5:0] ef, et;
        int cyc, exp_cyc;
        logic [19:0] r;
        eng_lat = lat;
        eng_bad = bv;
        eng_silent = sv;
        ef = '0;
        et = '0;
        exp_cyc = 1;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) begin
                start_q.push_back(3'(i));
                if (i == sv) begin
                    ef[i] = 1'b1;
                    et[i] = 1'b1;
                    exp_cyc += 66;
                end else begin
                    if (i == bv) ef[i] = 1'b1;
                    exp_cyc += 3 + lat;
                end
            end else begin
                exp_cyc += 1;
            end
        end
        result_q.push_back({exp_cyc[6:0], (m != 0) && (ef == 0), ef, et});
        pulseRun(m);
        checkOutput("busy_start", busy, 1);
        checkOutput("done_cleared", done, 0);
        cyc = 0;
        while (!done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        r = result_q.pop_front();
        checkOutput("done", done, 1);
        checkOutput("cycles", cyc, r[19:13]);
        checkOutput("busy_end", busy, 0);
        checkOutput("pass_all", pass_all, r[12]);
        checkOutput("fail_vec", fail_vec, r[11:6]);
        checkOutput("timeout_vec", timeout_vec, r[5:0]);
        checkOutput("starts_left", start_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass_all, 0);
        checkOutput("rst_fail", fail_vec, 0);
        checkOutput("rst_eng", {eng_start, eng_keysize, eng_decrypt, eng_block_in}, 0);
        checkOutput("rst_hex", hex, {6{7'b1000000}});
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(6'b111111, 3, -1, -1);
        applyStimulus(6'b111111, 3, 2, -1);
        applyStimulus(6'b111111, 3, -1, 5);
        applyStimulus(6'b010001, 1, -1, -1);
        applyStimulus(6'b000000, 1, -1, -1);

        applyStimulus(6'b000001, 2, -1, -1);
        disp_byte = 4'd15;
        #1 checkOutput("hex_win15", hex, tb_hex(tb_expected(0), 4'd15));
        disp_byte = 4'd0;
        #1 checkOutput("hex_win0", hex, tb_hex(tb_expected(0), 4'd0));
        disp_byte = 4'd14;
        #1 checkOutput("hex_win14", hex, tb_hex(tb_expected(0), 4'd14));

        eng_lat = 5;
        eng_bad = -1;
        eng_silent = -1;
        for (int i = 0; i < 4; i++) start_q.push_back(3'(i));
        pulseRun(6'b111111);
        guard = 0;
        while (start_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_vec3", start_q.size(), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_flags", {done, pass_all, fail_vec, timeout_vec}, 0);
        checkOutput("mid_rst_eng", {eng_start, eng_keysize, eng_decrypt, eng_block_in}, 0);
        checkOutput("mid_rst_hex", hex, {3{tb_seg(4'd0), tb_seg(4'd0)}});
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_idle", {busy, done}, 0);
        applyStimulus(6'b111111, 1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
